// File: rtl/systolic_job_arbiter.sv
// systolic_job_arbiter
// Time-shares one systolic array between NUM_REQ requesters. A round-robin
// grant picks one pending job, the operands are registered and held, the
// array is started with a one-cycle pulse, and the captured result goes back
// with the owner's ID over a valid/ready response channel.
// Optional feature: define SA_TIMEOUT_EN to add a WAIT-state watchdog that
// answers with rsp_error=1 and a zero result after TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps

module systolic_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int ARRAY_SIZE     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int ACCUM_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [NUM_REQ-1:0]                                          req_valid,
  output logic [NUM_REQ-1:0]                                          req_ready,
  input  logic [NUM_REQ*DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]         req_a_flat,
  input  logic [NUM_REQ*WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]       req_b_flat,
  output logic                                                        sa_start,
  output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]                 sa_matrix_a_flat,
  output logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]               sa_matrix_b_flat,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]                sa_result_flat,
  input  logic                                                        sa_done,
  output logic                                                        rsp_valid,
  input  logic                                                        rsp_ready,
  output logic [ID_WIDTH-1:0]                                         rsp_id,
  output logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]                rsp_result_flat,
  output logic                                                        rsp_error,
  output logic                                                        busy
);

  localparam int AW    = DATA_WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam int BW    = WEIGHT_WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations the ID field cannot represent
  if (NUM_REQ < 1 || ID_WIDTH < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("systolic_job_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               grant_found;
  logic [ID_WIDTH-1:0] job_id;

`ifdef SA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]   wd_cnt;
`endif

  // Round-robin scan: first pending requester at or after rr_ptr, wrapping
  always_comb begin
    int scan_idx;
    scan_idx    = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(scan_idx);
      end
    end
  end

  assign next_ptr = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);

  // Accept is combinational so the requester sees it in the grant cycle;
  // gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = (rst_n && state == IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;

`ifndef SA_TIMEOUT_EN
  assign rsp_error = 1'b0;
`endif

  // Job sequencer: grant, launch, wait for the array, hold the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      job_id           <= '0;
      sa_start         <= 1'b0;
      sa_matrix_a_flat <= '0;
      sa_matrix_b_flat <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_result_flat  <= '0;
      busy             <= 1'b0;
`ifdef SA_TIMEOUT_EN
      rsp_error        <= 1'b0;
      wd_cnt           <= '0;
`endif
    end else begin
      sa_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            sa_matrix_a_flat <= req_a_flat[grant_idx*AW +: AW];
            sa_matrix_b_flat <= req_b_flat[grant_idx*BW +: BW];
            job_id           <= ID_WIDTH'(grant_idx);
            rr_ptr           <= next_ptr;
            sa_start         <= 1'b1;
            busy             <= 1'b1;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef SA_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (sa_done) begin
            rsp_result_flat <= sa_result_flat;
            rsp_id          <= job_id;
            rsp_valid       <= 1'b1;
`ifdef SA_TIMEOUT_EN
            rsp_error       <= 1'b0;
`endif
            state           <= RESP;
          end
`ifdef SA_TIMEOUT_EN
          // sa_done has priority, so a late completion on the last cycle still succeeds
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_flat <= '0;
            rsp_id          <= job_id;
            rsp_valid       <= 1'b1;
            rsp_error       <= 1'b1;
            state           <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
